// File: rtl/com_responder_if.sv
// Host strobe/status bundle for com_responder: read/write strobes in,
// FIFO and transmitter status out. The shared data bus stays a plain inout.
interface com_responder_if;
    logic rdn;
    logic wrn;
    logic data_ready;
    logic tbre;
    logic tsre;

    modport master (output rdn, output wrn, input data_ready, input tbre, input tsre);
    modport slave  (input rdn, input wrn, output data_ready, output tbre, output tsre);
endinterface

// File: rtl/com_responder.sv
// 8N1 UART responder: one-byte TX holding register + shifter, RX deserializer
// feeding a small FIFO read over a shared 16-bit bus. Define COM_LOOPBACK_EN to feed txd into RX.
module com_responder #(
    parameter int CLK_DIV  = 434,
    parameter int RX_DEPTH = 4
) (
    input  logic            clk_50MHz,
    input  logic            rst,
    inout  wire  [15:0]     ram1_data,
    com_responder_if.slave  bus,
    output logic            txd,
    input  logic            rxd,
    output logic [1:0]      o_dbg_tx_state,
    output logic [1:0]      o_dbg_rx_state
);

    localparam int PW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam logic [11:0] DIV_LAST  = 12'(CLK_DIV - 1);
    localparam logic [11:0] HALF_LAST = 12'(CLK_DIV / 2 - 1);
    localparam logic [PW:0] DEPTH_C   = (PW + 1)'(RX_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // Host strobes: one register stage, events on the edge seen against raw input
    logic r_wrn_q, r_rdn_q;
    logic w_wr_evt, w_rd_evt;

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            r_wrn_q <= 1'b1;
            r_rdn_q <= 1'b1;
        end else begin
            r_wrn_q <= bus.wrn;
            r_rdn_q <= bus.rdn;
        end
    end

    assign w_wr_evt = r_wrn_q & ~bus.wrn;
    assign w_rd_evt = ~r_rdn_q & bus.rdn;

    // ---------------- transmitter ----------------
    state_t      r_tx_state, w_tx_state_nx;
    logic [11:0] r_tx_cnt, w_tx_cnt_nx;
    logic [2:0]  r_tx_bit, w_tx_bit_nx;
    logic [7:0]  r_tx_shift, w_tx_shift_nx;
    logic [7:0]  r_hold;
    logic        r_txd, w_txd_nx;
    logic        r_tbre, r_tsre, w_tsre_nx;
    logic        w_tx_load, w_tx_last;

    assign w_tx_last = (r_tx_cnt == DIV_LAST);

    always_comb begin
        w_tx_state_nx = r_tx_state;
        w_tx_cnt_nx   = r_tx_cnt + 12'd1;
        w_tx_bit_nx   = r_tx_bit;
        w_tx_shift_nx = r_tx_shift;
        w_txd_nx      = r_txd;
        w_tsre_nx     = r_tsre;
        w_tx_load     = 1'b0;
        case (r_tx_state)
            S_IDLE: begin
                w_tx_cnt_nx = 12'd0;
                w_txd_nx    = 1'b1;
                if (!r_tbre) begin
                    w_tx_load     = 1'b1;
                    w_tx_state_nx = S_START;
                    w_txd_nx      = 1'b0;
                    w_tsre_nx     = 1'b0;
                end
            end
            S_START: begin
                if (w_tx_last) begin
                    w_tx_state_nx = S_DATA;
                    w_tx_cnt_nx   = 12'd0;
                    w_tx_bit_nx   = 3'd0;
                    w_txd_nx      = r_tx_shift[0];
                end
            end
            S_DATA: begin
                if (w_tx_last) begin
                    w_tx_cnt_nx = 12'd0;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_nx = S_STOP;
                        w_txd_nx      = 1'b1;
                    end else begin
                        w_tx_bit_nx   = r_tx_bit + 3'd1;
                        w_tx_shift_nx = {1'b0, r_tx_shift[7:1]};
                        w_txd_nx      = r_tx_shift[1];
                    end
                end
            end
            S_STOP: begin
                if (w_tx_last) begin
                    w_tx_cnt_nx = 12'd0;
                    // A byte already waiting goes straight out with no idle gap
                    if (!r_tbre) begin
                        w_tx_load     = 1'b1;
                        w_tx_state_nx = S_START;
                        w_txd_nx      = 1'b0;
                    end else begin
                        w_tx_state_nx = S_IDLE;
                        w_tsre_nx     = 1'b1;
                    end
                end
            end
            default: w_tx_state_nx = S_IDLE;
        endcase
        if (w_tx_load) w_tx_shift_nx = r_hold;
    end

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= 12'd0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'h00;
            r_txd      <= 1'b1;
            r_tsre     <= 1'b1;
            r_tbre     <= 1'b1;
            r_hold     <= 8'h00;
        end else begin
            r_tx_state <= w_tx_state_nx;
            r_tx_cnt   <= w_tx_cnt_nx;
            r_tx_bit   <= w_tx_bit_nx;
            r_tx_shift <= w_tx_shift_nx;
            r_txd      <= w_txd_nx;
            r_tsre     <= w_tsre_nx;
            if (w_tx_load) begin
                r_tbre <= 1'b1;
            end else if (w_wr_evt && r_tbre) begin
                r_tbre <= 1'b0;
                r_hold <= ram1_data[7:0];
            end
        end
    end

    // ---------------- receiver ----------------
    logic        w_rx_in;
    logic        r_rx_meta, r_rx_sync, r_rx_prev;
    logic        w_rx_fall;
    state_t      r_rx_state, w_rx_state_nx;
    logic [11:0] r_rx_cnt, w_rx_cnt_nx;
    logic [2:0]  r_rx_bit, w_rx_bit_nx;
    logic [7:0]  r_rx_shift, w_rx_shift_nx;
    logic        w_rx_push;

`ifdef COM_LOOPBACK_EN
    assign w_rx_in = r_txd;
`else
    assign w_rx_in = rxd;
`endif

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= w_rx_in;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_rx_fall = r_rx_prev & ~r_rx_sync;

    always_comb begin
        w_rx_state_nx = r_rx_state;
        w_rx_cnt_nx   = r_rx_cnt + 12'd1;
        w_rx_bit_nx   = r_rx_bit;
        w_rx_shift_nx = r_rx_shift;
        w_rx_push     = 1'b0;
        case (r_rx_state)
            S_IDLE: begin
                w_rx_cnt_nx = 12'd0;
                if (w_rx_fall) w_rx_state_nx = S_START;
            end
            S_START: begin
                // Mid-start sample; a line already back high was only a glitch
                if (r_rx_cnt == HALF_LAST) begin
                    w_rx_cnt_nx   = 12'd0;
                    w_rx_bit_nx   = 3'd0;
                    w_rx_state_nx = r_rx_sync ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_rx_cnt == DIV_LAST) begin
                    w_rx_cnt_nx   = 12'd0;
                    w_rx_shift_nx = {r_rx_sync, r_rx_shift[7:1]};
                    w_rx_bit_nx   = r_rx_bit + 3'd1;
                    if (r_rx_bit == 3'd7) w_rx_state_nx = S_STOP;
                end
            end
            S_STOP: begin
                if (r_rx_cnt == DIV_LAST) begin
                    w_rx_cnt_nx   = 12'd0;
                    w_rx_push     = r_rx_sync;
                    w_rx_state_nx = S_IDLE;
                end
            end
            default: w_rx_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= 12'd0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'h00;
        end else begin
            r_rx_state <= w_rx_state_nx;
            r_rx_cnt   <= w_rx_cnt_nx;
            r_rx_bit   <= w_rx_bit_nx;
            r_rx_shift <= w_rx_shift_nx;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]  r_fifo [RX_DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [PW:0] r_count;
    logic        r_data_ready;
    logic        w_fifo_empty, w_fifo_full, w_push, w_pop;

    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == DEPTH_C);
    assign w_push       = w_rx_push & ~w_fifo_full;
    assign w_pop        = w_rd_evt & ~w_fifo_empty;

    always_ff @(posedge clk_50MHz) begin
        if (w_push) r_fifo[r_wr_ptr] <= r_rx_shift;
    end

    // Pointers wrap naturally since RX_DEPTH is a power of two
    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_data_ready <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_data_ready <= ~w_fifo_empty;
        end
    end

    // ---------------- bus and status ----------------
    logic       w_bus_drive;
    logic [7:0] w_rd_byte;

    assign w_bus_drive = ~bus.rdn & ~rst;
    assign w_rd_byte   = w_fifo_empty ? 8'h00 : r_fifo[r_rd_ptr];
    assign ram1_data   = w_bus_drive ? {8'h00, w_rd_byte} : 16'hzzzz;

    assign txd            = r_txd;
    assign bus.tbre       = r_tbre;
    assign bus.tsre       = r_tsre;
    assign bus.data_ready = r_data_ready;
    assign o_dbg_tx_state = r_tx_state;
    assign o_dbg_rx_state = r_rx_state;

endmodule

// File: tb/tb_com_responder.sv
// Directed + randomized bench for com_responder (CLK_DIV=8, RX_DEPTH=4):
// per-cycle TX waveform against a frame model, RX bytes against an expected queue.
module tb_com_responder;

    localparam int CLK_DIV  = 8;
    localparam int RX_DEPTH = 4;
    localparam int FRAME    = 10 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        txd;
    logic        rxd;
    logic [1:0]  dbg_tx, dbg_rx;
    wire  [15:0] ram1_data;
    logic [15:0] tb_data;
    logic        tb_drive;

    assign ram1_data = tb_drive ? tb_data : 16'hzzzz;

    com_responder_if bus_if ();

    com_responder #(.CLK_DIV(CLK_DIV), .RX_DEPTH(RX_DEPTH)) dut (
        .clk_50MHz      (clk),
        .rst            (rst),
        .ram1_data      (ram1_data),
        .bus            (bus_if.slave),
        .txd            (txd),
        .rxd            (rxd),
        .o_dbg_tx_state (dbg_tx),
        .o_dbg_rx_state (dbg_rx)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q  [$];
    logic [7:0] frm_q  [$];
    logic [7:0] pend_q [$];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Bit i of an 8N1 frame: start, eight data bits LSB first, stop
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i == 9) return 1'b1;
        return b[i-1];
    endfunction

    // Writes every byte of pend_q as soon as the holding register frees up and
    // checks txd/tsre every cycle against the back-to-back frames in frm_q.
    task automatic tx_run(input int ignored_at, input logic [7:0] upper);
        int nfr;
        logic [7:0] b;
        b = pend_q.pop_front();
        @(negedge clk);
        tb_data = {upper, b};
        bus_if.wrn = 1'b0;
        @(negedge clk);
        bus_if.wrn = 1'b1;
        chk("tbre_after_write", {15'd0, bus_if.tbre}, 16'd0);
        nfr = frm_q.size();
        for (int k = 0; k < nfr * FRAME + 4; k++) begin
            @(negedge clk);
            if (k < nfr * FRAME) begin
                chk("txd_frame", {15'd0, txd}, {15'd0, frame_bit(frm_q[k / FRAME], (k % FRAME) / CLK_DIV)});
                chk("tsre_busy", {15'd0, bus_if.tsre}, 16'd0);
            end else begin
                chk("txd_idle", {15'd0, txd}, 16'd1);
                chk("tsre_idle", {15'd0, bus_if.tsre}, 16'd1);
            end
            if (bus_if.wrn == 1'b0) begin
                bus_if.wrn = 1'b1;
            end else if (k == ignored_at) begin
                chk("tbre_full", {15'd0, bus_if.tbre}, 16'd0);
                tb_data = 16'h00FF;
                bus_if.wrn = 1'b0;
            end else if (pend_q.size() > 0 && bus_if.tbre) begin
                tb_data = {8'($urandom), pend_q.pop_front()};
                bus_if.wrn = 1'b0;
            end
        end
        chk("tbre_end", {15'd0, bus_if.tbre}, 16'd1);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        for (int i = 0; i < 10; i++) begin
            rxd = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
            repeat (CLK_DIV) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        if (stop && exp_q.size() < RX_DEPTH) exp_q.push_back(b);
    endtask

    task automatic do_read(input string tag);
        logic [15:0] exp_v;
        exp_v = 16'h0000;
        if (exp_q.size() > 0) exp_v = {8'h00, exp_q.pop_front()};
        @(negedge clk);
        tb_drive = 1'b0;
        bus_if.rdn = 1'b0;
        @(negedge clk);
        chk(tag, ram1_data, exp_v);
        bus_if.rdn = 1'b1;
        repeat (2) @(negedge clk);
        tb_drive = 1'b1;
        chk("data_ready_after_read", {15'd0, bus_if.data_ready}, {15'd0, exp_q.size() != 0});
    endtask

    initial begin
        int n;
        logic [7:0] b;
        rst        = 1'b1;
        rxd        = 1'b1;
        bus_if.rdn = 1'b1;
        bus_if.wrn = 1'b1;
        tb_drive   = 1'b1;
        tb_data    = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_txd", {15'd0, txd}, 16'd1);
        chk("rst_tbre", {15'd0, bus_if.tbre}, 16'd1);
        chk("rst_tsre", {15'd0, bus_if.tsre}, 16'd1);
        chk("rst_data_ready", {15'd0, bus_if.data_ready}, 16'd0);
        chk("rst_tx_state", {14'd0, dbg_tx}, 16'd0);
        chk("rst_rx_state", {14'd0, dbg_rx}, 16'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single frame of 8'h55 written as 16'h1255
        frm_q = '{8'h55};
        pend_q = '{8'h55};
        tx_run(-1, 8'h12);

        // Back-to-back A5/3C, plus a write while the holding register is full
        frm_q = '{8'hA5, 8'h3C};
        pend_q = '{8'hA5, 8'h3C};
        tx_run(2, 8'h00);

        // Random back-to-back bursts
        for (int r = 0; r < 2; r++) begin
            n = $urandom_range(2, 4);
            frm_q.delete();
            for (int i = 0; i < n; i++) frm_q.push_back(8'($urandom));
            pend_q = frm_q;
            tx_run(-1, 8'($urandom));
        end

        // Reset in the middle of a frame
        @(negedge clk);
        tb_data = {8'h00, 8'($urandom)};
        bus_if.wrn = 1'b0;
        @(negedge clk);
        bus_if.wrn = 1'b1;
        repeat ($urandom_range(20, 60)) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_txd", {15'd0, txd}, 16'd1);
        chk("midrst_tbre", {15'd0, bus_if.tbre}, 16'd1);
        chk("midrst_tsre", {15'd0, bus_if.tsre}, 16'd1);
        chk("midrst_data_ready", {15'd0, bus_if.data_ready}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("postrst_txd", {15'd0, txd}, 16'd1);
        chk("postrst_tsre", {15'd0, bus_if.tsre}, 16'd1);

`ifdef COM_LOOPBACK_EN
        frm_q = '{8'h7E};
        pend_q = '{8'h7E};
        tx_run(-1, 8'h00);
        exp_q.push_back(8'h7E);
        repeat (4) @(negedge clk);
        chk("loop_data_ready", {15'd0, bus_if.data_ready}, 16'd1);
        do_read("loop_read");
        b = 8'($urandom);
        frm_q = '{b};
        pend_q = '{b};
        tx_run(-1, 8'h00);
        exp_q.push_back(b);
        repeat (4) @(negedge clk);
        do_read("loop_read_rand");
`else
        // Single received byte
        send_frame(8'hC3, 1'b1);
        chk("rx_data_ready", {15'd0, bus_if.data_ready}, 16'd1);
        do_read("rx_read_c3");

        // Overflow: fifth byte dropped, then an extra read of the empty FIFO
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        chk("full_data_ready", {15'd0, bus_if.data_ready}, 16'd1);
        for (int i = 0; i < 5; i++) do_read("overflow_read");

        // Short low glitch is rejected
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_no_push", {15'd0, bus_if.data_ready}, 16'd0);

        // Framing error is discarded
        send_frame(8'($urandom), 1'b0);
        repeat (4) @(negedge clk);
        chk("framing_no_push", {15'd0, bus_if.data_ready}, 16'd0);

        // Random bursts with occasional framing errors
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) send_frame(8'($urandom), ($urandom_range(0, 5) != 0));
            chk("burst_data_ready", {15'd0, bus_if.data_ready}, {15'd0, exp_q.size() != 0});
            n = exp_q.size() + 1;
            for (int i = 0; i < n; i++) do_read("burst_read");
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/com_responder.md
COM_RESPONDER -- requirements
Module: com_responder

Interface
REQ-001 Parameter CLK_DIV, default 434, clk_50MHz cycles per serial bit (115200 baud); legal range 4..4095.
REQ-002 Parameter RX_DEPTH, default 4, RX FIFO entries; power of two, 2..16.
REQ-003 clk_50MHz  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ram1_data  inout  16  shared data bus; bits [7:0] carry the byte.
REQ-006 rdn  input  1  read strobe, active low.
REQ-007 wrn  input  1  write strobe, active low.
REQ-008 data_ready  output  1  high while RX FIFO non-empty.
REQ-009 tbre  output  1  transmit holding register empty.
REQ-010 tsre  output  1  transmit shift register empty (line idle).
REQ-011 txd  output  1  serial out, idle high.
REQ-012 rxd  input  1  serial in, asynchronous to clk_50MHz.

Function
REQ-013 Frame SHALL be 8N1: start 0, 8 data bits LSB first, stop 1; each bit exactly CLK_DIV cycles.
REQ-014 rdn and wrn SHALL be registered once; write event = registered wrn 1 then raw wrn 0; read-complete event = registered rdn 0 then raw rdn 1.
REQ-015 Write event with tbre=1 SHALL latch ram1_data[7:0] into holding register and clear tbre next cycle.
REQ-016 Write event with tbre=0 SHALL be ignored; holding register unchanged.
REQ-017 TX FSM states IDLE, START, DATA, STOP; IDLE->START when holding full, same cycle holding->shifter, tbre<=1, tsre<=0.
REQ-018 START->DATA after CLK_DIV cycles; DATA->STOP after 8 bits; STOP->IDLE after CLK_DIV cycles, tsre<=1, unless holding full then STOP->START directly (back-to-back, no idle gap) keeping tsre=0.
REQ-019 txd SHALL be a register output (no combinational glitch).
REQ-020 rxd SHALL pass a 2-flop synchronizer before use.
REQ-021 RX FSM states IDLE, START, DATA, STOP; IDLE->START on synchronized 1->0.
REQ-022 START samples at CLK_DIV/2 (integer division); sample 1 -> IDLE (glitch rejected), 0 -> DATA.
REQ-023 DATA samples each bit CLK_DIV cycles after previous sample; 8 samples -> STOP.
REQ-024 STOP sample 1 pushes byte to FIFO; sample 0 discards byte (framing error); both -> IDLE.
REQ-025 Push with FIFO full SHALL drop the new byte; FIFO contents unchanged.
REQ-026 While rdn=0, ram1_data SHALL be driven {8'h00, FIFO head}, or 16'h0000 if empty; otherwise high-Z.
REQ-027 Read-complete event SHALL pop one entry if non-empty; no effect if empty.
REQ-028 Simultaneous push and pop SHALL both occur; occupancy unchanged.
REQ-029 data_ready SHALL update the cycle after the FIFO pointer change.
REQ-030 FIFO pointers SHALL wrap modulo RX_DEPTH.

Reset
REQ-031 rst SHALL asynchronously force: tbre=1, tsre=1, txd=1, data_ready=0, both FSMs IDLE, FIFO empty, strobe registers 1, synchronizer 1.
REQ-032 rst mid-frame SHALL abort TX/RX immediately; in-flight bytes lost; ram1_data high-Z while rst=1.

Configuration
REQ-033 Macro COM_LOOPBACK_EN defined: RX synchronizer input SHALL be internal txd, rxd ignored; txd still driven.
REQ-034 Macro COM_LOOPBACK_EN undefined: RX input SHALL be rxd; no loopback logic present.

Verification (CLK_DIV=8, RX_DEPTH=4)
REQ-035 Reset mid-TX frame -> txd=1, tbre=1, tsre=1 same cycle; data_ready=0.
REQ-036 Write 16'h1255 -> txd 0,1,0,1,0,1,0,1,0,1 each 8 cycles; tbre=1 from shifter load; tsre=1 after stop bit.
REQ-037 Write 8'hA5 then 8'h3C while tbre=1 -> frames back-to-back, tsre stays 0 across boundary; third write while tbre=0 ignored.
REQ-038 Drive rxd frame 8'hC3 -> data_ready=1; rdn low -> ram1_data=16'h00C3; rdn high -> data_ready=0.
REQ-039 Send 5 frames 8'h01..8'h05 no reads -> reads return 01,02,03,04 then 16'h0000 with data_ready=0; 3-cycle rxd low pulse -> no push; stop bit 0 -> no push.
REQ-040 COM_LOOPBACK_EN defined, write 8'h7E -> data_ready=1 after ~10 bit times, read returns 16'h007E.
